// File: rtl/uart_rx_drain_ctrl.sv
// uart_rx_drain_ctrl: drains the UART RX FIFO in bursts. A burst starts on the threshold flag or after an idle-line timeout.
// Latency: IDLE->FETCH takes 1 cycle; the pop happens in FETCH and the byte is valid from the next cycle. Each byte takes at least 2 cycles.
// Backpressure: a held byte stays stable until m_ready; no further pop happens until the handshake.
//
// Ports:
//   pclk, preset_n           clock, synchronous active-low reset
//   ctrl_en                  receiver enable; low aborts the burst and holds IDLE
//   ctrl_shift_rx            16x oversample tick, drives the idle-line timeout
//   rx_ne/rx_busy/rx_rxf     FIFO not-empty, receiver mid-frame, FIFO threshold
//   rx_ov/rx_pe/rx_fe        FIFO overrun, head-byte parity/frame error
//   rx_data                  FIFO head byte (combinational from read pointer)
//   ctrl_data_rd             FIFO pop strobe, one cycle per byte
//   m_valid/m_ready/m_data/m_err  byte stream out, m_err = {fe,pe}
//   burst_done               one-cycle pulse after a burst ends
//   irq_timeout/ovf_sticky   sticky status flags
//   err_cnt                  saturating count of popped bytes with pe|fe
//   flag_clr                 clears sticky flags and err_cnt

module uart_rx_drain_ctrl #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TOUT_TICKS = 640,
  parameter int unsigned TOUT_W     = 10
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       ctrl_en,
  input  logic       ctrl_shift_rx,
  input  logic       rx_ne,
  input  logic       rx_busy,
  input  logic       rx_rxf,
  input  logic       rx_ov,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic [7:0] rx_data,
  output logic       ctrl_data_rd,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [1:0] m_err,
  output logic       burst_done,
  output logic       irq_timeout,
  output logic       ovf_sticky,
  output logic [7:0] err_cnt,
  input  logic       flag_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Five bits hold the burst count up to 16.
  localparam logic [4:0]        LP_MAX_BURST = 5'(MAX_BURST);
  localparam logic [TOUT_W-1:0] LP_TOUT      = TOUT_W'(TOUT_TICKS);

  state_t            r_state;
  logic [4:0]        r_bcnt;
  logic [TOUT_W-1:0] r_tcnt;
  logic              r_m_valid;
  logic [7:0]        r_m_data;
  logic [1:0]        r_m_err;
  logic              r_burst_done;
  logic              r_irq_timeout;
  logic              r_ovf_sticky;
  logic [7:0]        r_err_cnt;

  logic w_pop;
  logic w_pop_err;
  logic w_tout_hit;
  logic w_start;
  logic w_tcnt_clr;

  // The pop is gated by ctrl_en so that an abort never consumes a byte.
  assign w_pop      = (r_state == S_FETCH) & rx_ne & ctrl_en;
  assign w_pop_err  = w_pop & (rx_pe | rx_fe);
  assign w_tout_hit = (r_tcnt == LP_TOUT);
  assign w_start    = (r_state == S_IDLE) & ctrl_en & rx_ne & (rx_rxf | w_tout_hit);
  assign w_tcnt_clr = ~rx_ne | rx_busy | (r_state != S_IDLE) | ~ctrl_en;

  assign ctrl_data_rd = w_pop;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_err        = r_m_err;
  assign burst_done   = r_burst_done;
  assign irq_timeout  = r_irq_timeout;
  assign ovf_sticky   = r_ovf_sticky;
  assign err_cnt      = r_err_cnt;

  // Drain FSM and its registered stream outputs.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state      <= S_IDLE;
      r_bcnt       <= 5'd0;
      r_m_valid    <= 1'b0;
      r_m_data     <= 8'd0;
      r_m_err      <= 2'd0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      if (!ctrl_en) begin
        // Abort: drop any held byte; no burst_done is reported.
        r_state   <= S_IDLE;
        r_m_valid <= 1'b0;
        r_bcnt    <= 5'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (rx_ne) begin
              r_m_data  <= rx_data;
              r_m_err   <= {rx_fe, rx_pe};
              r_bcnt    <= r_bcnt + 5'd1;
              r_m_valid <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              // The FIFO ran dry between bytes, so the burst ends here.
              r_state      <= S_IDLE;
              r_burst_done <= 1'b1;
              r_bcnt       <= 5'd0;
            end
          end
          S_HOLD: begin
            if (m_ready) begin
              r_m_valid <= 1'b0;
              // rx_ne here already reflects the read pointer update from the pop.
              if (rx_ne && (r_bcnt < LP_MAX_BURST)) begin
                r_state <= S_FETCH;
              end else begin
                r_state      <= S_IDLE;
                r_burst_done <= 1'b1;
                r_bcnt       <= 5'd0;
              end
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
            r_bcnt    <= 5'd0;
          end
        endcase
      end
    end
  end

  // Idle-line timeout: counts ticks only while IDLE with data waiting and
  // the line quiet. It saturates at the threshold, so tout_hit holds until cleared.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_tcnt <= '0;
    end else if (w_tcnt_clr) begin
      r_tcnt <= '0;
    end else if (ctrl_shift_rx && !w_tout_hit) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as flag_clr wins.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_irq_timeout <= 1'b0;
      r_ovf_sticky  <= 1'b0;
    end else begin
      if (w_start && !rx_rxf && w_tout_hit) begin
        r_irq_timeout <= 1'b1;
      end else if (flag_clr) begin
        r_irq_timeout <= 1'b0;
      end

      if (rx_ov && ctrl_en) begin
        r_ovf_sticky <= 1'b1;
      end else if (flag_clr) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  // Error-byte counter, saturating at 255. A counted pop beats a clear.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_pop_err) begin
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end else if (flag_clr) begin
      r_err_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed testbench for uart_rx_drain_ctrl, built with MAX_BURST=4.
// The RX FIFO is modelled as a queue. Pops are applied just after the clock edge.
// Outputs are sampled on the falling edge.

module tb_uart_rx_drain_ctrl;

  logic       pclk;
  logic       preset_n;
  logic       ctrl_en;
  logic       ctrl_shift_rx;
  logic       rx_ne;
  logic       rx_busy;
  logic       rx_rxf;
  logic       rx_ov;
  logic       rx_pe;
  logic       rx_fe;
  logic [7:0] rx_data;
  logic       ctrl_data_rd;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] m_err;
  logic       burst_done;
  logic       irq_timeout;
  logic       ovf_sticky;
  logic [7:0] err_cnt;
  logic       flag_clr;

  uart_rx_drain_ctrl #(
    .MAX_BURST (4),
    .TOUT_TICKS(640),
    .TOUT_W    (10)
  ) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .ctrl_en      (ctrl_en),
    .ctrl_shift_rx(ctrl_shift_rx),
    .rx_ne        (rx_ne),
    .rx_busy      (rx_busy),
    .rx_rxf       (rx_rxf),
    .rx_ov        (rx_ov),
    .rx_pe        (rx_pe),
    .rx_fe        (rx_fe),
    .rx_data      (rx_data),
    .ctrl_data_rd (ctrl_data_rd),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_err        (m_err),
    .burst_done   (burst_done),
    .irq_timeout  (irq_timeout),
    .ovf_sticky   (ovf_sticky),
    .err_cnt      (err_cnt),
    .flag_clr     (flag_clr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int rd_empty = 0;

  logic [9:0] fifo_q[$];  // {fe, pe, data}
  logic [9:0] got_q[$];   // {m_err, m_data} at each handshake

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    rx_ne = (fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      {rx_fe, rx_pe, rx_data} = fifo_q[0];
    end else begin
      {rx_fe, rx_pe, rx_data} = 10'd0;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    fifo_q.push_back({fe, pe, d});
    upd_fifo();
  endtask

  // Called at a falling edge. It records the current cycle, advances one clock,
  // and returns at the next falling edge.
  task automatic step();
    logic       pop;
    logic [9:0] tmp;
    pop = ctrl_data_rd;
    if (pop) pops++;
    if (ctrl_data_rd && !rx_ne) rd_empty++;
    if (m_valid && m_ready) got_q.push_back({m_err, m_data});
    @(posedge pclk);
    #1;
    if (pop && fifo_q.size() != 0) tmp = fifo_q.pop_front();
    upd_fifo();
    @(negedge pclk);
  endtask

  task automatic wait_bd(input string tag, input int budget);
    int n;
    n = 0;
    while (!burst_done && n < budget) begin
      step();
      n++;
    end
    check_val(tag, {31'd0, burst_done}, 32'd1);
  endtask

  initial begin
    int n;
    int unstable;
    int extra;
    preset_n      = 1'b0;
    ctrl_en       = 1'b1;
    ctrl_shift_rx = 1'b0;
    rx_busy       = 1'b0;
    rx_rxf        = 1'b0;
    rx_ov         = 1'b0;
    m_ready       = 1'b0;
    flag_clr      = 1'b0;
    upd_fifo();
    @(negedge pclk);
    repeat (3) step();

    // Reset state
    check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_m_data_err", {22'd0, m_err, m_data}, 32'd0);
    check_val("rst_flags", {29'd0, burst_done, irq_timeout, ovf_sticky}, 32'd0);
    check_val("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_val("rst_rd", {31'd0, ctrl_data_rd}, 32'd0);
    preset_n = 1'b1;
    step();

    // Three clean bytes on threshold
    got_q.delete();
    pops = 0;
    m_ready = 1'b1;
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    rx_rxf = 1'b1;
    wait_bd("t3_burst_done", 40);
    check_val("t3_pops", pops, 3);
    check_val("t3_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_val("t3_b0", {22'd0, got_q[0]}, 32'h011);
      check_val("t3_b1", {22'd0, got_q[1]}, 32'h022);
      check_val("t3_b2", {22'd0, got_q[2]}, 32'h033);
    end
    rx_rxf = 1'b0;
    repeat (2) step();

    // Sixteen bytes with MAX_BURST=4: bursts of four, immediate re-entry
    got_q.delete();
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0, 1'b0);
    rx_rxf = 1'b1;
    wait_bd("mb_first_bd", 40);
    check_val("mb_first_burst_len", got_q.size(), 4);
    check_val("mb_fifo_left", fifo_q.size(), 12);
    step();
    check_val("mb_reenter_fetch", {31'd0, ctrl_data_rd}, 32'd1);
    n = 0;
    while (got_q.size() < 16 && n < 200) begin
      step();
      n++;
    end
    check_val("mb_total", got_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) check_val("mb_byte", {22'd0, got_q[i]}, 32'h40 + i);
    end
    rx_rxf = 1'b0;
    repeat (4) step();

    // Idle-line timeout with one byte waiting
    got_q.delete();
    pops = 0;
    push(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 639; i++) begin
      ctrl_shift_rx = 1'b1;
      step();
      ctrl_shift_rx = 1'b0;
      step();
    end
    check_val("to_no_pop_639", pops, 0);
    check_val("to_irq_639", {31'd0, irq_timeout}, 32'd0);
    ctrl_shift_rx = 1'b1;
    step();
    ctrl_shift_rx = 1'b0;
    check_val("to_idle_at_hit", {31'd0, ctrl_data_rd}, 32'd0);
    step();
    check_val("to_fetch", {31'd0, ctrl_data_rd}, 32'd1);
    check_val("to_irq_set", {31'd0, irq_timeout}, 32'd1);
    wait_bd("to_burst_done", 10);
    check_val("to_byte", got_q.size() == 1 ? {22'd0, got_q[0]} : 32'hDEAD, 32'h05A);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check_val("to_irq_clr", {31'd0, irq_timeout}, 32'd0);

    // Backpressure: m_ready low for ten cycles in HOLD
    got_q.delete();
    pops = 0;
    m_ready = 1'b0;
    push(8'hA5, 1'b0, 1'b0);
    push(8'h3C, 1'b0, 1'b0);
    rx_rxf = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin
      step();
      n++;
    end
    check_val("bp_valid", {31'd0, m_valid}, 32'd1);
    unstable = 0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!m_valid || m_data !== 8'hA5) unstable++;
      if (ctrl_data_rd) extra++;
    end
    check_val("bp_stable", unstable, 0);
    check_val("bp_no_2nd_pop", extra, 0);
    check_val("bp_pops", pops, 1);
    m_ready = 1'b1;
    wait_bd("bp_burst_done", 20);
    check_val("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_val("bp_b0", {22'd0, got_q[0]}, 32'h0A5);
      check_val("bp_b1", {22'd0, got_q[1]}, 32'h03C);
    end

    // Error flags and saturating err_cnt
    got_q.delete();
    push(8'h77, 1'b1, 1'b0);
    n = 0;
    while (got_q.size() < 1 && n < 20) begin
      step();
      n++;
    end
    check_val("er_fe_byte", got_q.size() == 1 ? {22'd0, got_q[0]} : 32'hDEAD, 32'h277);
    step();
    check_val("er_cnt_1", {24'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) push(8'(i), 1'b0, 1'b1);
    n = 0;
    while (got_q.size() < 301 && n < 3000) begin
      step();
      n++;
    end
    check_val("er_total", got_q.size(), 301);
    check_val("er_pe_last", got_q.size() == 301 ? {22'd0, got_q[300]} : 32'hDEAD, 32'h12B);
    check_val("er_cnt_sat", {24'd0, err_cnt}, 32'd255);
    rx_rxf = 1'b0;
    repeat (3) step();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check_val("er_cnt_clr", {24'd0, err_cnt}, 32'd0);

    // ctrl_en dropped in HOLD
    got_q.delete();
    m_ready = 1'b0;
    push(8'hC3, 1'b0, 1'b0);
    rx_rxf = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin
      step();
      n++;
    end
    check_val("en_hold_valid", {31'd0, m_valid}, 32'd1);
    ctrl_en = 1'b0;
    step();
    check_val("en_drop_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    repeat (2) step();
    check_val("en_no_handshake", got_q.size(), 0);
    ctrl_en = 1'b1;
    push(8'hD4, 1'b0, 1'b0);
    step();
    check_val("en_idle_then_fetch", {31'd0, ctrl_data_rd}, 32'd1);
    wait_bd("en_burst_done", 20);
    check_val("en_byte", got_q.size() == 1 ? {22'd0, got_q[0]} : 32'hDEAD, 32'h0D4);
    rx_rxf = 1'b0;

    // Overrun sticky flag
    rx_ov = 1'b1;
    step();
    rx_ov = 1'b0;
    check_val("ov_set", {31'd0, ovf_sticky}, 32'd1);
    rx_ov = 1'b1;
    flag_clr = 1'b1;
    step();
    rx_ov = 1'b0;
    check_val("ov_set_wins", {31'd0, ovf_sticky}, 32'd1);
    step();
    flag_clr = 1'b0;
    check_val("ov_clr", {31'd0, ovf_sticky}, 32'd0);
    ctrl_en = 1'b0;
    rx_ov = 1'b1;
    step();
    rx_ov = 1'b0;
    ctrl_en = 1'b1;
    check_val("ov_ignored_disabled", {31'd0, ovf_sticky}, 32'd0);

    check_val("rd_never_empty", rd_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
